// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result bundle for the nibble-serial adder sequencer.
interface nibble_serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit carry-lookahead slice,
// one nibble per clock, LSB nibble first.
module nibble_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input logic                     clk,
   input logic                     rst,
   nibble_serial_add_ctrl_if.slave bus
);
   localparam int unsigned N     = WIDTH / 4;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned BIT_W = IDX_W + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_finish;
   logic               w_last;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_work;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [BIT_W-1:0]   w_base;
   logic [3:0]         w_na;
   logic [3:0]         w_nb;
   logic [3:0]         w_g;
   logic [3:0]         w_p;
   logic [4:0]         w_c;
   logic [3:0]         w_nib_sum;
   logic [WIDTH-1:0]   w_work_nxt;
   logic               w_ovf;

   assign w_last = (r_idx == IDX_W'(N - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // 4-bit carry-lookahead slice on the current nibble
   always_comb begin
      w_base    = {r_idx, 2'b00};
      w_na      = r_a[w_base +: 4];
      w_nb      = r_b[w_base +: 4];
      w_g       = w_na & w_nb;
      w_p       = w_na ^ w_nb;
      w_c[0]    = r_carry;
      w_c[1]    = w_g[0] | (w_p[0] & w_c[0]);
      w_c[2]    = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      w_c[3]    = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_c[4]    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_nib_sum = w_p ^ w_c[3:0];
   end

   // Working register with the current nibble merged in; B is already inverted for subtract
   always_comb begin
      w_work_nxt                = r_work;
      w_work_nxt[w_base +: 4]   = w_nib_sum;
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_work_nxt[WIDTH-1] != r_a[WIDTH-1]);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= w_finish;
         if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_idx   <= '0;
         end else if (r_state == S_RUN) begin
            r_work  <= w_work_nxt;
            r_carry <= w_c[4];
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
         end
         if (w_finish) begin
            r_sum  <= w_work_nxt;
            r_cout <= w_c[4];
            r_ovf  <= w_ovf;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
endmodule
